// File: rtl/fft32_cmul_round.sv
`default_nettype none
// fft32_cmul_round: combines twiddle products, rounds half-up, saturates; 2-stage valid/ready pipe.
// Rev 1.0 -- initial release
module fft32_cmul_round #(
   parameter int PROD_WIDTH = 28,
   parameter int DOUT_WIDTH = 16,
   parameter int FRAC_BITS  = 12,
   parameter int FRAME_LEN  = 32
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [PROD_WIDTH-1:0] p_rr,
   input  logic signed [PROD_WIDTH-1:0] p_ii,
   input  logic signed [PROD_WIDTH-1:0] p_ri,
   input  logic signed [PROD_WIDTH-1:0] p_ir,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DOUT_WIDTH-1:0] out_re,
   output logic signed [DOUT_WIDTH-1:0] out_im,
   output logic                         out_last,
   output logic                         ovf,
   input  logic                         clear_ovf
);

   localparam int c_CNT_W = $clog2(FRAME_LEN);
   localparam int c_SW    = PROD_WIDTH + 2;
   localparam logic [c_CNT_W-1:0]   c_LAST = c_CNT_W'(FRAME_LEN - 1);
   localparam logic signed [c_SW-1:0] c_HALF = c_SW'(1) << (FRAC_BITS - 1);
   localparam logic signed [c_SW-1:0] c_MAX  = c_SW'(2 ** (DOUT_WIDTH - 1) - 1);
   localparam logic signed [c_SW-1:0] c_MIN  = ~c_MAX;

   logic                         r_s1v;
   logic                         r_s2v;
   logic signed [PROD_WIDTH:0]   r_re_sum;
   logic signed [PROD_WIDTH:0]   r_im_sum;
   logic signed [DOUT_WIDTH-1:0] r_out_re;
   logic signed [DOUT_WIDTH-1:0] r_out_im;
   logic                         r_ovf;
   logic [c_CNT_W-1:0]           r_cnt;

   logic                         w_adv1;
   logic                         w_adv2;
   logic signed [PROD_WIDTH:0]   w_re_sum;
   logic signed [PROD_WIDTH:0]   w_im_sum;
   logic signed [c_SW-1:0]       w_re_rnd;
   logic signed [c_SW-1:0]       w_im_rnd;
   logic signed [c_SW-1:0]       w_re_shf;
   logic signed [c_SW-1:0]       w_im_shf;
   logic signed [DOUT_WIDTH-1:0] w_re_q;
   logic signed [DOUT_WIDTH-1:0] w_im_q;
   logic                         w_re_sat;
   logic                         w_im_sat;
   logic                         w_ovf_set;

   assign w_adv2   = !r_s2v | out_ready;
   assign w_adv1   = !r_s1v | w_adv2;
   assign in_ready = w_adv1;

   // One guard bit on each sum keeps the add/subtract from wrapping.
   assign w_re_sum = {p_rr[PROD_WIDTH-1], p_rr} - {p_ii[PROD_WIDTH-1], p_ii};
   assign w_im_sum = {p_ri[PROD_WIDTH-1], p_ri} + {p_ir[PROD_WIDTH-1], p_ir};

   assign w_re_rnd = {r_re_sum[PROD_WIDTH], r_re_sum} + c_HALF;
   assign w_im_rnd = {r_im_sum[PROD_WIDTH], r_im_sum} + c_HALF;
   assign w_re_shf = w_re_rnd >>> FRAC_BITS;
   assign w_im_shf = w_im_rnd >>> FRAC_BITS;

   always_comb begin
      w_re_sat = 1'b1;
      w_im_sat = 1'b1;
      if (w_re_shf > c_MAX)      w_re_q = c_MAX[DOUT_WIDTH-1:0];
      else if (w_re_shf < c_MIN) w_re_q = c_MIN[DOUT_WIDTH-1:0];
      else begin
         w_re_q   = w_re_shf[DOUT_WIDTH-1:0];
         w_re_sat = 1'b0;
      end
      if (w_im_shf > c_MAX)      w_im_q = c_MAX[DOUT_WIDTH-1:0];
      else if (w_im_shf < c_MIN) w_im_q = c_MIN[DOUT_WIDTH-1:0];
      else begin
         w_im_q   = w_im_shf[DOUT_WIDTH-1:0];
         w_im_sat = 1'b0;
      end
   end

   assign w_ovf_set = w_adv2 & r_s1v & (w_re_sat | w_im_sat);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_s1v    <= 1'b0;
         r_re_sum <= '0;
         r_im_sum <= '0;
      end else if (w_adv1) begin
         r_s1v <= in_valid;
         if (in_valid) begin
            r_re_sum <= w_re_sum;
            r_im_sum <= w_im_sum;
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_s2v    <= 1'b0;
         r_out_re <= '0;
         r_out_im <= '0;
      end else if (w_adv2) begin
         r_s2v <= r_s1v;
         if (r_s1v) begin
            r_out_re <= w_re_q;
            r_out_im <= w_im_q;
         end
      end
   end

   // A new saturation outranks a simultaneous clear.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)      r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_cnt <= '0;
      else if (r_s2v && out_ready)
         r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
   end

   assign out_valid = r_s2v;
   assign out_re    = r_out_re;
   assign out_im    = r_out_im;
   assign out_last  = r_s2v & (r_cnt == c_LAST);
   assign ovf       = r_ovf;

endmodule
`default_nettype wire
